// File: rtl/word_serializer.sv
// Parallel-to-serial front end for the serial 1010 detector.
// Accepts WIDTH-bit words on a valid/ready handshake and shifts them out one
// bit per clock. A one-word holding register lets words stream with no gaps.
module word_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;

  logic             accept;
  logic             cur_bit;
  logic [WIDTH-1:0] shift_adv;

  // A word is taken whenever it is offered and the holding slot is free.
  assign din_ready = ~hold_full_q;
  assign accept    = din_valid & ~hold_full_q;

  // The bit on the wire sits at the outgoing end of the shifter.
  assign cur_bit   = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
  assign shift_adv = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0}
                               : {1'b0, shift_q[WIDTH-1:1]};

  // Next-state: load, advance, refill from the holding slot, or go idle.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;

    unique case (state_q)
      IDLE: begin
        // The holding slot is always empty in IDLE, so go straight to the shifter.
        if (accept) begin
          shift_d = din;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == LAST_IDX) begin
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            cnt_d       = '0;
          end else if (accept) begin
            shift_d = din;
            cnt_d   = '0;
          end else begin
            shift_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else begin
          shift_d = shift_adv;
          cnt_d   = cnt_q + 1'b1;
          if (accept) begin
            hold_d      = din;
            hold_full_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and shifter state; reset discards any in-flight or held word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      hold_full_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      hold_full_q <= hold_full_d;
    end
  end

  // Holding-register payload.
  // NOTE: data-only storage has no reset; hold_full_q alone says whether it is meaningful.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  // Outputs decoded purely from flops, so they change only at clock edges or reset.
  assign ser_valid   = (state_q == SHIFT);
  assign ser_out     = ser_valid & cur_bit;
  assign frame_start = ser_valid & (cnt_q == '0);
  assign frame_end   = ser_valid & (cnt_q == LAST_IDX);
  assign busy        = ser_valid | hold_full_q;

  // Upstream must keep a stalled word steady until it is taken.
  a_din_stable: assert property (@(posedge clk) disable iff (!rst)
                                 (din_valid && !din_ready) |=> $stable(din));

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer: one MSB-first and one LSB-first
// instance, a bit-level scoreboard, a vector table and corner-case sequences.
module tb_word_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] din         [2];
  logic       din_valid   [2];
  logic       din_ready   [2];
  logic       ser_out     [2];
  logic       ser_valid   [2];
  logic       frame_start [2];
  logic       frame_end   [2];
  logic       busy        [2];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic b;
    logic fs;
    logic fe;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   run_len [2];
  int   max_run [2];

  word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .din(din[0]), .din_valid(din_valid[0]),
    .din_ready(din_ready[0]), .ser_out(ser_out[0]), .ser_valid(ser_valid[0]),
    .frame_start(frame_start[0]), .frame_end(frame_end[0]), .busy(busy[0])
  );

  word_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .din(din[1]), .din_valid(din_valid[1]),
    .din_ready(din_ready[1]), .ser_out(ser_out[1]), .ser_valid(ser_valid[1]),
    .frame_start(frame_start[1]), .frame_end(frame_end[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected bit stream of one word, built from the word and the bit order.
  task automatic push_word(input int s, input logic [7:0] w);
    exp_t e;
    int   idx;
    for (int i = 0; i < 8; i++) begin
      idx  = (s == 0) ? 7 - i : i;
      e.b  = w[idx];
      e.fs = (i == 0);
      e.fe = (i == 7);
      if (s == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  // Offer a word until taken; returns the number of stalled edges.
  task automatic send_word(input int s, input logic [7:0] w, output int stalls);
    logic rdy;
    logic taken;
    int   k;
    din[s]       = w;
    din_valid[s] = 1'b1;
    stalls       = 0;
    taken        = 1'b0;
    k            = 0;
    while (!taken && k < 200) begin
      rdy = din_ready[s];
      tick();
      if (rdy) taken = 1'b1;
      else     stalls++;
      k++;
    end
    if (taken) push_word(s, w);
    else       check("accept_timeout", 32'(taken), 32'd1);
    din_valid[s] = 1'b0;
  endtask

  task automatic drain(input int s);
    int k;
    k = 0;
    while (((s == 0) ? q0.size() : q1.size()) > 0 && k < 100) begin
      tick();
      k++;
    end
    check("drain", 32'((s == 0) ? q0.size() : q1.size()), 32'd0);
    tick();
  endtask

  // Scoreboard monitor: compare every output cycle away from the rising edge.
  task automatic mon(input int s);
    exp_t e;
    if (ser_valid[s]) begin
      if (((s == 0) ? q0.size() : q1.size()) == 0) begin
        check($sformatf("sb_underflow%0d", s), 32'((s == 0) ? q0.size() : q1.size()), 32'd1);
      end else begin
        e = (s == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("bit%0d", s),
              32'({ser_out[s], frame_start[s], frame_end[s]}), 32'(e));
      end
      run_len[s]++;
      if (run_len[s] > max_run[s]) max_run[s] = run_len[s];
    end else begin
      check($sformatf("idle_out%0d", s),
            32'({ser_out[s], frame_start[s], frame_end[s]}), 32'd0);
      run_len[s] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      mon(0);
      mon(1);
    end
  end

  typedef struct {
    logic       msb;
    logic [7:0] word;
    logic [7:0] exp_bits;  // transmit order, first bit at [7]
  } vec_t;

  vec_t vecs [8];

  initial begin
    int         st;
    int         s;
    int         k;
    logic [7:0] cap;
    logic       anyv;

    vecs[0] = '{1'b1, 8'hA5, 8'b1010_0101};
    vecs[1] = '{1'b0, 8'h01, 8'b1000_0000};
    vecs[2] = '{1'b1, 8'h80, 8'b1000_0000};
    vecs[3] = '{1'b0, 8'h80, 8'b0000_0001};
    vecs[4] = '{1'b1, 8'h3C, 8'b0011_1100};
    vecs[5] = '{1'b0, 8'hB4, 8'b0010_1101};
    vecs[6] = '{1'b1, 8'hFF, 8'b1111_1111};
    vecs[7] = '{1'b0, 8'h00, 8'b0000_0000};

    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      din[i] = '0; din_valid[i] = 1'b0; run_len[i] = 0; max_run[i] = 0;
    end

    // Reset state
    #2;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_outs%0d", i),
            32'({ser_out[i], ser_valid[i], frame_start[i], frame_end[i], busy[i]}), 32'd0);
      check($sformatf("reset_ready%0d", i), 32'(din_ready[i]), 32'd1);
    end
    tick();
    rst = 1'b1;
    tick();

    // Single words through both bit orders
    for (int v = 0; v < 8; v++) begin
      s = vecs[v].msb ? 0 : 1;
      send_word(s, vecs[v].word, st);
      cap = '0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        cap = {cap[6:0], ser_out[s]};
        tick();
      end
      check($sformatf("vec%0d_bits", v), 32'(cap), 32'(vecs[v].exp_bits));
      check($sformatf("vec%0d_idle_after", v), 32'(ser_valid[s]), 32'd0);
      tick();
    end

    // Back-to-back streaming with a stalled third word
    max_run[0] = 0;
    send_word(0, 8'hF0, st);
    check("b2b_first_stall", 32'(st), 32'd0);
    send_word(0, 8'h0F, st);
    check("b2b_ready_low", 32'(din_ready[0]), 32'd0);
    check("b2b_busy", 32'(busy[0]), 32'd1);
    send_word(0, 8'h3C, st);
    check("b2b_third_stalls", 32'(st), 32'd7);
    drain(0);
    check("b2b_contiguous", 32'(max_run[0]), 32'd24);

    // Accept on the last-bit edge with an empty holding register
    max_run[0] = 0;
    send_word(0, 8'h81, st);
    k = 0;
    while (!frame_end[0] && k < 20) begin
      tick();
      k++;
    end
    check("edge_saw_frame_end", 32'(frame_end[0]), 32'd1);
    check("edge_hold_empty", 32'(din_ready[0]), 32'd1);
    send_word(0, 8'h7E, st);
    check("edge_no_stall", 32'(st), 32'd0);
    check("edge_frame_start", 32'(frame_start[0]), 32'd1);
    drain(0);
    check("edge_contiguous", 32'(max_run[0]), 32'd16);

    // Asynchronous reset at bit 3 with a word held
    send_word(0, 8'hAA, st);
    send_word(0, 8'h55, st);
    check("rst_pre_busy", 32'(busy[0]), 32'd1);
    check("rst_pre_ready", 32'(din_ready[0]), 32'd0);
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid_outs",
          32'({ser_out[0], ser_valid[0], frame_start[0], frame_end[0], busy[0]}), 32'd0);
    check("rst_mid_ready", 32'(din_ready[0]), 32'd1);
    q0.delete();
    q1.delete();
    run_len[0] = 0;
    tick();
    rst = 1'b1;
    anyv = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      anyv = anyv | ser_valid[0] | busy[0];
      tick();
    end
    check("rst_no_resume", 32'(anyv), 32'd0);

    // Legal stall on the LSB-first instance: stalled word arrives intact
    send_word(1, 8'hC3, st);
    send_word(1, 8'h5A, st);
    send_word(1, 8'h96, st);
    check("lsb_stall", 32'(st), 32'd7);
    drain(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
